sram_resp: RTL and testbench

SRAM_RESP -- requirements
Module: sram_resp

---
 rtl/sram_pkg.sv | 40 ++++
 rtl/sram_resp_array.sv | 31 +++
 rtl/sram_resp.sv | 129 ++++++++++++
 tb/tb_sram_resp.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// +----------------------------------------------------------------------------+
// | sram_pkg : shared widths, active-low control levels, command decode         |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package sram_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic EN_N  = 1'b0;
  localparam logic DIS_N = 1'b1;

  typedef enum logic [2:0] {
    CMD_DESELECT,
    CMD_WRITE,
    CMD_READ,
    CMD_CONFLICT,
    CMD_STANDBY
  } cmd_e;

  function automatic cmd_e decode_cmd(input logic cen, input logic wen, input logic oen);
    cmd_e c;
    if (cen == DIS_N)                       c = CMD_DESELECT;
    else if (wen == EN_N && oen == DIS_N)   c = CMD_WRITE;
    else if (wen == DIS_N && oen == EN_N)   c = CMD_READ;
    else if (wen == EN_N && oen == EN_N)    c = CMD_CONFLICT;
    else                                    c = CMD_STANDBY;
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_resp_array.sv
// +----------------------------------------------------------------------------+
// | sram_resp_array : single-port storage, synchronous write, read-first read   |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module sram_resp_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset so they survive a reset pulse.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
    if (we) mem[addr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/sram_resp.sv
// +----------------------------------------------------------------------------+
// | sram_resp : SRAM responder with write protect, read pipeline, counters, FSM |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module sram_resp
  import sram_pkg::*;
#(
  parameter int DATA_W = sram_pkg::DATA_W,
  parameter int ADDR_W = sram_pkg::ADDR_W,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_cen,
  input  logic              s_wen,
  input  logic              s_oen,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_ddata,
  output logic [DATA_W-1:0] s_qdata,
  output logic              q_valid,
  input  logic              wp_ena,
  input  logic [ADDR_W-1:0] wp_lo,
  input  logic [ADDR_W-1:0] wp_hi,
  input  logic              cnt_clr,
  output logic [15:0]       wr_cnt,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       err_cnt,
  output logic              fault
);

  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_FAULT  = 1'b1;

  cmd_e              cmd;
  logic              wr_req;
  logic              rd_req;
  logic              conflict;
  logic              wp_hit;
  logic              wr_do;
  logic              err_evt;
  logic [DATA_W-1:0] arr_rdata;
  logic [DATA_W-1:0] pipe_data;
  logic [RD_LAT-1:0] rd_pipe;
  logic [0:0]        state;

  // An inverted window (wp_lo > wp_hi) can never satisfy both bounds, so it is empty.
  always_comb begin
    cmd      = decode_cmd(s_cen, s_wen, s_oen);
    conflict = (cmd == CMD_CONFLICT);
    rd_req   = (cmd == CMD_READ);
    wr_req   = (cmd == CMD_WRITE) || conflict;
    wp_hit   = wp_ena && (s_addr >= wp_lo) && (s_addr <= wp_hi);
    wr_do    = wr_req && !wp_hit;
    err_evt  = (wr_req && wp_hit) || conflict;
  end

  sram_resp_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (wr_do),
    .re    (rd_req),
    .addr  (s_addr),
    .wdata (s_ddata),
    .rdata (arr_rdata)
  );

  // The array register is the first read stage; latency 2 adds one data stage.
  generate
    if (RD_LAT == 1) begin : g_lat1
      assign pipe_data = arr_rdata;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_pipe <= '0;
        else       rd_pipe <= rd_req;
      end
    end else begin : g_lat2
      logic [DATA_W-1:0] data_dly;
      always_ff @(posedge clk) begin
        if (rd_pipe[0]) data_dly <= arr_rdata;
      end
      assign pipe_data = data_dly;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_pipe <= '0;
        else       rd_pipe <= {rd_pipe[0], rd_req};
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_qdata <= '0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= rd_pipe[RD_LAT-1];
      if (rd_pipe[RD_LAT-1]) s_qdata <= pipe_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      err_cnt <= '0;
    end else if (cnt_clr) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (wr_do)   wr_cnt  <= sat_inc(wr_cnt);
      if (rd_req)  rd_cnt  <= sat_inc(rd_cnt);
      if (err_evt) err_cnt <= sat_inc(err_cnt);
    end
  end

  // A conflict in the same cycle as a clear keeps the fault set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         state <= ST_NORMAL;
    else if (conflict) state <= ST_FAULT;
    else if (cnt_clr)  state <= ST_NORMAL;
  end

  assign fault = (state == ST_FAULT);

endmodule

`default_nettype wire

// File: tb/tb_sram_resp.sv
// +----------------------------------------------------------------------------+
// | tb_sram_resp : directed self-checking bench for sram_resp (RD_LAT = 2)      |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sram_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_cen, s_wen, s_oen;
  logic [9:0]  s_addr;
  logic [7:0]  s_ddata;
  logic [7:0]  s_qdata;
  logic        q_valid;
  logic        wp_ena;
  logic [9:0]  wp_lo, wp_hi;
  logic        cnt_clr;
  logic [15:0] wr_cnt, rd_cnt, err_cnt;
  logic        fault;

  int total = 0;
  int bad   = 0;

  sram_resp #(.DATA_W(8), .ADDR_W(10), .RD_LAT(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_cen   (s_cen),
    .s_wen   (s_wen),
    .s_oen   (s_oen),
    .s_addr  (s_addr),
    .s_ddata (s_ddata),
    .s_qdata (s_qdata),
    .q_valid (q_valid),
    .wp_ena  (wp_ena),
    .wp_lo   (wp_lo),
    .wp_hi   (wp_hi),
    .cnt_clr (cnt_clr),
    .wr_cnt  (wr_cnt),
    .rd_cnt  (rd_cnt),
    .err_cnt (err_cnt),
    .fault   (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one command, then advance past the edge that samples it.
  task automatic cmd(input logic cen, input logic wen, input logic oen,
                     input logic [9:0] a, input logic [7:0] d);
    s_cen = cen; s_wen = wen; s_oen = oen; s_addr = a; s_ddata = d;
    step();
  endtask

  task automatic wr(input logic [9:0] a, input logic [7:0] d);
    cmd(1'b0, 1'b0, 1'b1, a, d);
  endtask

  task automatic rd(input logic [9:0] a);
    cmd(1'b0, 1'b1, 1'b0, a, 8'h00);
  endtask

  task automatic idle();
    cmd(1'b1, 1'b1, 1'b1, 10'h000, 8'h00);
  endtask

  task automatic clear();
    cnt_clr = 1'b1;
    idle();
    cnt_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cnt_clr = 1'b0; wp_ena = 1'b0; wp_lo = '0; wp_hi = '0;
    s_cen = 1'b1; s_wen = 1'b1; s_oen = 1'b1; s_addr = '0; s_ddata = '0;
    repeat (3) step();
    check("rst_qdata", s_qdata, 0);
    check("rst_qvalid", q_valid, 0);
    check("rst_wr_cnt", wr_cnt, 0);
    check("rst_rd_cnt", rd_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_fault", fault, 0);
    reset = 1'b0;

    // Basic write/read at both address extremes
    wr(10'h000, 8'h5A);
    wr(10'h3FF, 8'hA5);
    rd(10'h000);
    check("b2b_qv_k0", q_valid, 0);
    rd(10'h3FF);
    check("b2b_qv_k1", q_valid, 0);
    idle();
    check("rd0_qv", q_valid, 1);
    check("rd0_data", s_qdata, 8'h5A);
    idle();
    check("rd3ff_qv", q_valid, 1);
    check("rd3ff_data", s_qdata, 8'hA5);
    idle();
    check("qv_pulse", q_valid, 0);
    check("qdata_hold", s_qdata, 8'hA5);
    check("basic_wr_cnt", wr_cnt, 2);
    check("basic_rd_cnt", rd_cnt, 2);
    check("basic_err_cnt", err_cnt, 0);

    // Write protection
    wr(10'h180, 8'h22);
    wr(10'h1FF, 8'hC3);
    clear();
    check("clr_wr_cnt", wr_cnt, 0);
    wp_ena = 1'b1; wp_lo = 10'h100; wp_hi = 10'h1FF;
    wr(10'h180, 8'h11);
    wr(10'h200, 8'h33);
    rd(10'h180);
    rd(10'h200);
    idle();
    check("wp_blocked_data", s_qdata, 8'h22);
    idle();
    check("wp_outside_data", s_qdata, 8'h33);
    check("wp_err_cnt", err_cnt, 1);
    check("wp_wr_cnt", wr_cnt, 1);
    check("wp_fault", fault, 0);
    wr(10'h1FF, 8'hEE);
    wr(10'h0FF, 8'h44);
    check("wp_hi_edge_err", err_cnt, 2);
    check("wp_lo_below_wr", wr_cnt, 2);
    wp_lo = 10'h300; wp_hi = 10'h2FF;
    wr(10'h2FF, 8'h55);
    check("wp_empty_err", err_cnt, 2);
    check("wp_empty_wr", wr_cnt, 3);
    wp_ena = 1'b0;
    rd(10'h1FF);
    rd(10'h2FF);
    idle();
    check("wp_hi_edge_data", s_qdata, 8'hC3);
    idle();
    check("wp_empty_data", s_qdata, 8'h55);

    // Conflict sets fault and still writes
    clear();
    cmd(1'b0, 1'b0, 1'b0, 10'h010, 8'h77);
    check("cf_fault", fault, 1);
    check("cf_err_cnt", err_cnt, 1);
    check("cf_wr_cnt", wr_cnt, 1);
    check("cf_rd_cnt", rd_cnt, 0);
    idle();
    check("cf_qv_k1", q_valid, 0);
    idle();
    check("cf_qv_k2", q_valid, 0);
    idle();
    check("cf_fault_sticky", fault, 1);
    clear();
    check("cf_clr_fault", fault, 0);
    check("cf_clr_err", err_cnt, 0);
    check("cf_clr_wr", wr_cnt, 0);
    rd(10'h010);
    idle();
    idle();
    check("cf_mem_data", s_qdata, 8'h77);
    cnt_clr = 1'b1;
    cmd(1'b0, 1'b0, 1'b0, 10'h011, 8'h66);
    cnt_clr = 1'b0;
    check("setwins_fault", fault, 1);
    check("setwins_err", err_cnt, 0);
    check("setwins_wr", wr_cnt, 0);
    clear();
    check("setwins_clr", fault, 0);

    // Read-first: a later write does not disturb an in-flight read
    wr(10'h020, 8'h01);
    rd(10'h020);
    wr(10'h020, 8'h02);
    idle();
    check("rf_old_qv", q_valid, 1);
    check("rf_old_data", s_qdata, 8'h01);
    rd(10'h020);
    idle();
    idle();
    check("rf_new_data", s_qdata, 8'h02);

    // Reset with reads in flight
    rd(10'h000);
    rd(10'h3FF);
    rd(10'h180);
    rd(10'h200);
    idle();
    reset = 1'b1;
    #1;
    check("rr_qv_assert", q_valid, 0);
    check("rr_qdata_assert", s_qdata, 0);
    step();
    check("rr_qv_during", q_valid, 0);
    step();
    reset = 1'b0;
    idle();
    check("rr_qv_after1", q_valid, 0);
    idle();
    check("rr_qv_after2", q_valid, 0);
    check("rr_qdata_after", s_qdata, 0);
    check("rr_rd_cnt", rd_cnt, 0);
    rd(10'h3FF);
    rd(10'h180);
    idle();
    check("rr_mem_3ff", s_qdata, 8'hA5);
    idle();
    check("rr_mem_180", s_qdata, 8'h22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
